// File: rtl/ram4k_arbiter.sv
// Two-requester arbiter in front of a 4K x 16 single-port RAM (IDLE/ACCESS/DONE).
// Define RAM4K_ARB_FIXED_PRIO_EN for fixed priority (req0 wins); default is round-robin.
module ram4k_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        we0,
  input  logic [11:0] addr0,
  input  logic [15:0] wdata0,
  output logic        ack0,
  output logic [15:0] rdata0,
  input  logic        req1,
  input  logic        we1,
  input  logic [11:0] addr1,
  input  logic [15:0] wdata1,
  output logic        ack1,
  output logic [15:0] rdata1,
  output logic        ram_load,
  output logic [11:0] ram_addr,
  output logic [15:0] ram_in,
  input  logic [15:0] ram_out,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state_r;
  // Owner of the current transaction; in round-robin builds also the last-granted pointer.
  logic   winner_r;
  logic   grant_valid_s;
  logic   grant_s;

  // Winner selection for the IDLE grant edge.
  always_comb begin
    grant_valid_s = req0 | req1;
    grant_s       = 1'b0;
`ifdef RAM4K_ARB_FIXED_PRIO_EN
    if (req0) begin
      grant_s = 1'b0;
    end else begin
      grant_s = 1'b1;
    end
`else
    if (req0 && req1) begin
      grant_s = ~winner_r;
    end else if (req1) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
`endif
  end

  // Transaction FSM with registered RAM, ack, rdata and busy outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= IDLE;
`ifdef RAM4K_ARB_FIXED_PRIO_EN
      winner_r <= 1'b0;
`else
      winner_r <= 1'b1;
`endif
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      rdata0   <= 16'h0000;
      rdata1   <= 16'h0000;
      ram_load <= 1'b0;
      ram_addr <= 12'h000;
      ram_in   <= 16'h0000;
      busy     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          ack0     <= 1'b0;
          ack1     <= 1'b0;
          ram_load <= 1'b0;
          if (grant_valid_s) begin
            winner_r <= grant_s;
            busy     <= 1'b1;
            state_r  <= ACCESS;
            // The RAM output registers double as the latched request.
            if (grant_s) begin
              ram_addr <= addr1;
              ram_in   <= wdata1;
              ram_load <= we1;
            end else begin
              ram_addr <= addr0;
              ram_in   <= wdata0;
              ram_load <= we0;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        ACCESS: begin
          ram_load <= 1'b0;
          if (!ram_load) begin
            if (winner_r) begin
              rdata1 <= ram_out;
            end else begin
              rdata0 <= ram_out;
            end
          end
          ack0    <= ~winner_r;
          ack1    <= winner_r;
          state_r <= DONE;
        end
        DONE: begin
          ack0    <= 1'b0;
          ack1    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          ack0     <= 1'b0;
          ack1     <= 1'b0;
          ram_load <= 1'b0;
          busy     <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/ram4k_arbiter.md
RAM4K_ARBITER -- requirements
Module: ram4k_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk (rising edge) and rst_n (sampled only on the clk rising edge, 0 = reset).
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk      input   1   system clock
- rst_n    input   1   synchronous active-low reset
- req0     input   1   requester 0 access request, held until ack0
- we0      input   1   requester 0 write (1) / read (0)
- addr0    input   12  requester 0 word address
- wdata0   input   16  requester 0 write data
- ack0     output  1   requester 0 completion pulse, one cycle
- rdata0   output  16  requester 0 read data, valid while ack0=1
- req1, we1, addr1, wdata1, ack1, rdata1: as for requester 0, same widths
- ram_load output  1   RAM write enable
- ram_addr output  12  RAM address
- ram_in   output  16  RAM write data
- ram_out  input   16  RAM read data, combinational from ram_addr
- busy     output  1   1 while a transaction is in progress

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, ACCESS and DONE.
REQ-004 IDLE: on a clk edge with req0 or req1 high, the block SHALL select a winner, latch its we/addr/wdata internally and move to ACCESS. With no request it SHALL stay in IDLE.
REQ-005 ACCESS: for exactly one cycle, ram_addr and ram_in SHALL be the latched values and ram_load SHALL equal the latched we. At the closing edge, ram_out SHALL be captured into the winner's rdata register and the state SHALL move to DONE.
REQ-006 DONE: the winner's ack SHALL be 1 for exactly one cycle and the state SHALL return to IDLE. Both req inputs SHALL be ignored in DONE.
REQ-007 Latency from the req-sampling edge to ack high SHALL be 2 cycles. A transaction SHALL occupy 3 cycles (IDLE, ACCESS, DONE).
REQ-008 Outside ACCESS, ram_load SHALL be 0, and ram_addr/ram_in SHALL hold their last driven values.
REQ-009 busy SHALL be 1 in ACCESS and DONE and 0 in IDLE.
REQ-010 Requester inputs SHALL be sampled only at the IDLE grant edge. Changes to them during ACCESS or DONE SHALL have no effect.
REQ-011 rdataX SHALL update only after a read granted to requester X. A write SHALL leave rdataX unchanged. The rdata of the non-winning requester SHALL never change.
REQ-012 Arbitration SHALL default to round-robin: if both requests are high, the winner is the requester not granted most recently. A single request SHALL always win.
REQ-013 If a requester keeps req high in the cycle after its ack, this SHALL be treated as a new request and arbitrated normally.
REQ-014 ack0 and ack1 SHALL never be high in the same cycle.

Reset
REQ-015 While rst_n=0 at a clk edge, the block SHALL load: state IDLE, ack0=ack1=0, rdata0=rdata1=0, ram_load=0, ram_addr=0, ram_in=0, busy=0, and the round-robin pointer set so that requester 0 wins the first tie.
REQ-016 A reset asserted during ACCESS or DONE SHALL abort the transaction with no ack issued. A RAM write driven during that ACCESS cycle still completes at the reset edge.

Configuration
REQ-017 When the macro RAM4K_ARB_FIXED_PRIO_EN is defined, arbitration SHALL be fixed priority: req0 always beats req1, and no round-robin pointer is implemented.
REQ-018 When RAM4K_ARB_FIXED_PRIO_EN is undefined, the round-robin behaviour of REQ-012 SHALL apply. All other requirements are identical in both builds.

Verification
REQ-019 Write then read: req0, we0=1, addr0=12'h00A, wdata0=16'h1234 gives ack0 2 cycles later with ram_load=1 for one cycle. A following read of 12'h00A gives rdata0=16'h1234 while ack0=1.
REQ-020 Simultaneous requests from reset: req0 and req1 held high for 4 transactions. Round-robin build: ack order 0,1,0,1. With the macro defined: ack order 0,0,0,0.
REQ-021 Input stability: after the grant edge, change addr1 from 12'hFFF to 12'h000 during ACCESS. The RAM is still accessed at 12'hFFF and rdata1 equals the contents of 12'hFFF.
REQ-022 Mid-operation reset: rst_n=0 during ACCESS of a write to 12'h010 with 16'hBEEF. No ack is issued, all outputs go to their reset values next cycle, and a later read of 12'h010 returns 16'hBEEF.
REQ-023 Idle and isolation: with no requests for 10 cycles, busy=0 and ram_load=0 throughout. A write by requester 1 leaves rdata0 unchanged.
